// File: rtl/reg_file_init.sv
// Integer register file with a post-reset clear sweep.
// The storage array has no per-entry reset. After rst drops, a sweep FSM writes zero to
// registers 1..REGS-1 and then raises ready. x0 reads as zero and is never written.
// An optional write-to-read bypass forwards wd3 to a same-cycle read of the written register.
module reg_file_init #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REGS   = 32,
  parameter int unsigned AW     = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic            we3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            ready
);

  typedef enum logic [1:0] {
    StResetHold,
    StClear,
    StRun
  } state_e;

  localparam logic [AW-1:0] LastReg = AW'(REGS - 1);
  localparam logic [AW-1:0] FirstReg = AW'(1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] mem_q [REGS];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // Next-state logic and the single memory write port shared by the sweep and normal writes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = a3;
    mem_wdata = wd3;
    case (state_q)
      StResetHold: begin
        state_d = StClear;
      end
      StClear: begin
        // Sweep owns the write port; we3 is dropped, not queued.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (ptr_q == LastReg) begin
          state_d = StRun;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + FirstReg;
        end
      end
      StRun: begin
        mem_we = we3 && (a3 != '0);
      end
      default: begin
        state_d = StResetHold;
        ptr_d   = FirstReg;
        ready_d = 1'b0;
      end
    endcase
    // A reset edge must not commit a sweep or user write.
    if (rst) begin
      mem_we = 1'b0;
    end
  end

  // FSM, sweep pointer and registered ready; reset restarts the sweep from register 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StResetHold;
      ptr_q   <= FirstReg;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Storage array, intentionally without reset so it maps onto RAM-style cells.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    if (!ready_q) begin
      val = '0;
    end else if (addr == '0) begin
      val = '0;
    end else if (BYPASS && we3 && (a3 == addr)) begin
      val = wd3;
    end else begin
      val = mem_q[addr];
    end
    return val;
  endfunction

  // Combinational read ports; zero until the sweep completes so no X escapes.
  always_comb begin
    rd1 = read_port(a1);
    rd2 = read_port(a2);
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_init.sv
// Scoreboard bench for reg_file_init: one instance with bypass and one without share stimulus.
// Each driven cycle pushes its hand-computed expectation; a negedge monitor pops and compares.
module tb_reg_file_init;

  logic        clk;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        ready, nb_ready;
  logic        req;

  typedef struct {
    string       name;
    logic        rdy;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] n1;
    logic [31:0] n2;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  reg_file_init #(.XLEN(32), .REGS(32), .AW(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
    .rd1(rd1), .rd2(rd2), .ready(ready)
  );

  reg_file_init #(.XLEN(32), .REGS(32), .AW(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .we3(we3), .wd3(wd3),
    .rd1(nb_rd1), .rd2(nb_rd2), .ready(nb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are valid every driven cycle; compare away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (req) begin
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        vectors++;
        if (ready !== e.rdy || nb_ready !== e.rdy || rd1 !== e.e1 || rd2 !== e.e2 ||
            nb_rd1 !== e.n1 || nb_rd2 !== e.n2) begin
          miscompares++;
          $display("FAIL %s (vec %0d): got ready=%b/%b rd1=%h rd2=%h nb_rd1=%h nb_rd2=%h ; required ready=%b rd1=%h rd2=%h nb_rd1=%h nb_rd2=%h",
                   e.name, vectors, ready, nb_ready, rd1, rd2, nb_rd1, nb_rd2,
                   e.rdy, e.e1, e.e2, e.n1, e.n2);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the response expected before the next rising edge.
  task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra1, input logic [4:0] ra2, input bit rdy,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] n1, input logic [31:0] n2, input string nm);
    exp_t e;
    rst = r; we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2;
    e.name = nm; e.rdy = rdy; e.e1 = e1; e.e2 = e2; e.n1 = n1; e.n2 = n2;
    sb_q.push_back(e);
    req = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] ra1, input logic [4:0] ra2, input bit rdy,
                    input logic [31:0] e1, input logic [31:0] e2, input string nm);
    cyc(1'b0, 1'b0, 5'd0, 32'h0, ra1, ra2, rdy, e1, e2, e1, e2, nm);
  endtask

  // Release reset, then expect ready low before E0 and after E0..E30, high after E31.
  task automatic sweep(input string nm);
    cyc(1'b0, 1'b1, 5'd4, 32'h66, 5'd4, 5'd4, 1'b0, 0, 0, 0, 0, {nm, "_release"});
    for (int k = 1; k <= 31; k++) begin
      if (k == 21)
        cyc(1'b0, 1'b1, 5'd31, 32'h55, 5'd31, 5'd31, 1'b0, 0, 0, 0, 0, {nm, "_wr31"});
      else if (k == 31)
        cyc(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd1, 1'b0, 0, 0, 0, 0, {nm, "_wr3"});
      else
        rd(5'(k), 5'(31 - k), 1'b0, 0, 0, {nm, "_busy"});
    end
    for (int i = 1; i <= 31; i++) begin
      rd(5'(i), 5'(32 - i), 1'b1, 0, 0, {nm, "_zero"});
    end
  endtask

  initial begin
    rst = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; req = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 5'd9, 32'hAAAA, 5'd9, 5'd0, 1'b0, 0, 0, 0, 0, "reset_hold");
    end
    sweep("sweep1");

    cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b1,
        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, "wr5");
    rd(5'd5, 5'd5, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, "rd5");
    cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 0, 0, 0, 0, "wr_x0");
    rd(5'd0, 5'd5, 1'b1, 0, 32'hDEADBEEF, "rd_x0");
    cyc(1'b0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd5, 1'b1,
        32'h11, 32'hDEADBEEF, 0, 32'hDEADBEEF, "wr7_11");
    cyc(1'b0, 1'b1, 5'd7, 32'h22, 5'd1, 5'd7, 1'b1, 0, 32'h22, 0, 32'h11, "wr7_22");
    rd(5'd7, 5'd7, 1'b1, 32'h22, 32'h22, "rd7");
    cyc(1'b0, 1'b1, 5'd8, 32'hA5A55A5A, 5'd7, 5'd8, 1'b1,
        32'h22, 32'hA5A55A5A, 32'h22, 32'h0, "wr8");
    rd(5'd8, 5'd5, 1'b1, 32'hA5A55A5A, 32'hDEADBEEF, "rd8");

    // Reset is synchronous: the cycle asserting it still sees RUN contents.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd8, 1'b1,
        32'hDEADBEEF, 32'hA5A55A5A, 32'hDEADBEEF, 32'hA5A55A5A, "rst_edge");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0, 0, 0, 0, 0, "rst_hold2");
    // Release, let 10 edges pass (E0..E9), then a one-edge reset mid-sweep.
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd8, 1'b0, 0, 0, 0, 0, "rel2");
    for (int k = 1; k <= 9; k++) begin
      rd(5'd7, 5'(k), 1'b0, 0, 0, "partial_sweep");
    end
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd8, 1'b0, 0, 0, 0, 0, "mid_rst");
    sweep("sweep2");

    req = 1'b0;
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d pending, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
